// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_pkg
// Description : Shared types, gate bit positions and golden-model helpers
//               for the mux-built basic gate array sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_GATES = 7;

  // Bit positions of each gate inside gate_res / fail_mask
  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOT  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  // Golden response of the whole gate array for one {A,B} vector.
  // The NOT gate only observes A.
  function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g            = '0;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_NOR]  = ~(a | b);
    g[GATE_NAND] = ~(a & b);
    g[GATE_NOT]  = ~a;
    g[GATE_XOR]  = a ^ b;
    g[GATE_XNOR] = ~(a ^ b);
    return g;
  endfunction

  // Number of set bits in a gate-wide vector (at most 7, fits 3 bits)
  function automatic logic [2:0] popcount7(input logic [NUM_GATES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sweep_checker_golden.sv
`default_nettype none
// ============================================================================
// Module      : gate_golden
// Description : Combinational golden model of the seven-gate array. Usable
//               standalone as a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_golden
  import gate_sweep_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] expected_o
);

  assign expected_o = expected_gates(a_i, b_i);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker
// Description : Drives all four {A,B} vectors into the gate array, waits a
//               programmable settle time per vector, compares the seven gate
//               outputs with the golden model and accumulates a saturating
//               error count, a sticky per-gate fail mask and a pass flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE = 2,   // cycles each vector is held, 1..15
  parameter int ERR_W  = 5    // error counter width
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_GATES-1:0] gate_res,
  output logic                 A,
  output logic                 B,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [NUM_GATES-1:0] fail_mask
);

  // Sum is formed wide enough that err + 7 can never wrap before clamping
  localparam int               SUM_W       = ERR_W + 4;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [SUM_W-1:0] ERR_MAX     = SUM_W'((1 << ERR_W) - 1);

  state_e               state_q;
  logic [1:0]           vec_q;
  logic [3:0]           settle_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [ERR_W-1:0]     err_q;
  logic [ERR_W-1:0]     err_d;
  logic [NUM_GATES-1:0] mask_q;
  logic [NUM_GATES-1:0] mask_d;
  logic [NUM_GATES-1:0] exp_gates;
  logic [NUM_GATES-1:0] mismatch;
  logic [SUM_W-1:0]     err_sum;

  // A is the MSB of the vector index, B the LSB: sweep order 00,01,10,11
  gate_golden u_golden (
    .a_i        (vec_q[1]),
    .b_i        (vec_q[0]),
    .expected_o (exp_gates)
  );

  // Score the current vector: mismatch bits, saturating error total, sticky mask
  always_comb begin
    mismatch = gate_res ^ exp_gates;
    err_sum  = SUM_W'(err_q) + SUM_W'(popcount7(mismatch));
    err_d    = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
    mask_d   = mask_q | mismatch;
  end

  // Sweep FSM with registered stimulus and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= 2'd0;
      settle_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      mask_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_DRIVE;
            vec_q    <= 2'd0;
            settle_q <= 4'd0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            err_q    <= '0;
            mask_q   <= '0;
          end
        end
        ST_DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        ST_CHECK: begin
          err_q  <= err_d;
          mask_q <= mask_d;
          if (vec_q == 2'd3) begin
            // Result is final here, so pass and done appear together
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0) && (mask_d == '0);
          end else begin
            state_q  <= ST_DRIVE;
            vec_q    <= vec_q + 2'd1;
            settle_q <= 4'd0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign A         = vec_q[1];
  assign B         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_checker
// Description : Self-checking bench for gate_sweep_checker. Two instances
//               (ERR_W=5 and ERR_W=4) run in lockstep against a modelled gate
//               array with selectable faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

  localparam int SETTLE = 2;
  localparam int VEC_CYC = SETTLE + 1;
  localparam int DONE_K = 4 * VEC_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] gate_res5, gate_res4;
  logic       A5, B5, busy5, done5, pass5;
  logic       A4, B4, busy4, done4, pass4;
  logic [4:0] err5;
  logic [3:0] err4;
  logic [6:0] mask5, mask4;

  int         mode;
  logic [6:0] rnd_tab [4];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  gate_sweep_checker #(.SETTLE(SETTLE), .ERR_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_res(gate_res5),
    .A(A5), .B(B5), .busy(busy5), .done(done5), .pass(pass5),
    .err_count(err5), .fail_mask(mask5)
  );

  gate_sweep_checker #(.SETTLE(SETTLE), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_res(gate_res4),
    .A(A4), .B(B4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_mask(mask4)
  );

  // Correct gate array: {xnor, xor, not, nand, nor, or, and}
  function automatic logic [6:0] ideal_gates(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~a, ~(a & b), ~(a | b), a | b, a & b};
  endfunction

  // Gate array as built, with the selected fault
  function automatic logic [6:0] array_out(input int m, input logic a, input logic b,
                                           input logic [6:0] corrupt);
    logic [6:0] g;
    g = ideal_gates(a, b);
    case (m)
      1:       g[5] = 1'b0;   // XOR stuck at 0
      2:       g    = ~g;     // every output inverted
      3:       g[4] = ~b;     // NOT wired to B
      4:       g    = g ^ corrupt;
      default: ;
    endcase
    return g;
  endfunction

  // Modelled gate arrays respond to each DUT's own stimulus
  always_comb gate_res5 = array_out(mode, A5, B5, rnd_tab[{A5, B5}]);
  always_comb gate_res4 = array_out(mode, A4, B4, rnd_tab[{A4, B4}]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs5();
    return {15'b0, busy5, done5, A5, B5, pass5, mask5, err5};
  endfunction

  function automatic logic [31:0] obs4();
    return {16'b0, busy4, done4, A4, B4, pass4, mask4, err4};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " d5"}, obs5(), 32'h0);
    check({tag, " d4"}, obs4(), 32'h0);
  endtask

  // One sweep; k counts rising edges after the start edge (edge 0).
  // abort_k >= 0 pulls reset right after sampling at that k.
  task automatic sweep(input string name, input int m, input bit hold, input int abort_k);
    logic [6:0] mm [4];
    int         pc [4];
    int         nchk, total, vec;
    logic [6:0] emask;
    bit         e_busy, e_done, e_pass;
    int         e5, e4;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      vv    = 2'(v);
      mm[v] = array_out(m, vv[1], vv[0], rnd_tab[v]) ^ ideal_gates(vv[1], vv[0]);
      pc[v] = $countones(mm[v]);
    end
    mode  = m;
    start = 1'b1;
    for (int k = 0; k <= DONE_K + 1; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      nchk  = (k >= DONE_K) ? 4 : k / VEC_CYC;
      vec   = (k >= DONE_K) ? 3 : k / VEC_CYC;
      total = 0;
      emask = '0;
      for (int v = 0; v < nchk; v++) begin
        total += pc[v];
        emask |= mm[v];
      end
      e_busy = (k < DONE_K);
      e_done = (k == DONE_K);
      e_pass = (k >= DONE_K) && (total == 0);
      e5     = (total > 31) ? 31 : total;
      e4     = (total > 15) ? 15 : total;
      check($sformatf("%s k%0d d5", name, k), obs5(),
            {15'b0, e_busy, e_done, 2'(vec), e_pass, emask, 5'(e5)});
      check($sformatf("%s k%0d d4", name, k), obs4(),
            {16'b0, e_busy, e_done, 2'(vec), e_pass, emask, 4'(e4)});
      if (k == abort_k) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_zero($sformatf("%s rst_now", name));
        repeat (2) begin
          @(negedge clk);
          check_zero($sformatf("%s rst_hold", name));
        end
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    for (int j = 0; j < 4; j++) rnd_tab[j] = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    sweep("good",       0, 1'b0, -1);
    sweep("xor_stuck0", 1, 1'b0, -1);
    sweep("all_inv",    2, 1'b0, -1);
    sweep("not_as_nb",  3, 1'b0, -1);

    // start held high: back-to-back sweeps, counters cleared on each start
    sweep("hold1", 1, 1'b1, -1);
    sweep("hold2", 2, 1'b1, -1);
    sweep("hold3", 0, 1'b0, -1);

    // reset during the second vector's DRIVE, then a clean sweep
    sweep("abort",     2, 1'b0, VEC_CYC + 1);
    sweep("after_rst", 0, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        rnd_tab[j] = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      end
      sweep($sformatf("rand%0d", i), 4, (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
    end

    start = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus-and-check stage for the mux-built basic gate array: AND, OR, NOR, NAND, NOT, XOR and XNOR, each built from 2x1 muxes.
- **Upstream role:** on `start` it drives all four `{A,B}` combinations into the gate array.
- **Downstream role:** it waits a programmable settle time per vector, samples the seven gate outputs and compares them against a built-in golden model.
- **Result:** accumulated error count, a sticky per-gate fail mask and a pass flag.

It replaces hand-run display loops with a self-checking hardware harness that can sit on-chip or in a bench.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `ERR_W`, default 5: error counter width; counter saturates at 2^ERR_W-1.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a sweep; sampled only in IDLE.
- `gate_res`  in  7: gate outputs. [0]=and, [1]=or, [2]=nor, [3]=nand, [4]=not(A), [5]=xor, [6]=xnor.
- `A`, `B`  out  1 each: registered stimulus to the gate array.
- `busy`  out  1: high from the cycle after `start` until DONE is reached.
- `done`  out  1: one-cycle pulse at the end of a sweep.
- `pass`  out  1: 1 if the last sweep had zero mismatches; held until the next `start`.
- `err_count`  out  ERR_W: total mismatching bits over the sweep, saturating.
- `fail_mask`  out  7: sticky OR of per-gate mismatches, same bit order as `gate_res`.

## Operation
- **States:** IDLE, DRIVE, CHECK, DONE. The encoding is an enum in the package.
- **IDLE:** `busy`=0.
  - On `start`=1: go to DRIVE.
  - Same edge: vec=0 (so `{A,B}`=2'b00), settle counter=0, clear `err_count`, `fail_mask` and `pass`.
- **DRIVE:** the settle counter increments each cycle. When it reaches SETTLE-1, go to CHECK.
- **CHECK (one cycle):**
  - Compute mismatch = `gate_res` ^ expected(vec).
  - `err_count` += popcount(mismatch), saturating at the max value.
  - `fail_mask` |= mismatch.
  - If vec==3: go to DONE.
  - Otherwise: vec+1 and go to DRIVE, with the settle counter cleared.
- **DONE (one cycle):**
  - `done`=1.
  - `pass` = (`err_count`==0 and `fail_mask`==0).
  - Return to IDLE with `busy`=0. `A`, `B` hold 2'b11 until the next start.
- **Expected outputs:** computed combinationally from vec: A&B, A|B, ~(A|B), ~(A&B), ~A, A^B, ~(A^B).
- **Start handling:** `start` is ignored in DRIVE, CHECK and DONE. There is no queuing. A `start` that is high in the IDLE cycle after DONE begins a new sweep.
- **Reset state:**
  - All outputs 0: `A`=`B`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0.
  - State=IDLE, vec=0.
- **Reset mid-sweep:** aborts immediately, with no `done` pulse. Results are cleared.

## Timing
- `start` is sampled at edge 0. `busy`, `A` and `B` are valid from edge 0 onward.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in DRIVE plus 1 in CHECK.
- `done` is high in cycle 4*(SETTLE+1). With SETTLE=2 this is cycle 12 after the start edge. `busy` drops at the same edge `done` rises.
- `gate_res` must be stable at the CHECK edge. The gate array is combinational, so SETTLE≥1 suffices in RTL simulation.
- `err_count` and `fail_mask` update only at CHECK edges. `pass` updates only at the DONE edge and at start.

## Structure
- **`gate_sweep_pkg`:**
  - State enum.
  - Gate index localparams (GATE_AND=0 … GATE_XNOR=6).
  - NUM_GATES=7.
  - Function expected_gates(logic a, logic b) returning logic[6:0].
- **Sub-module `gate_golden`:** purely combinational wrapper of expected_gates. It is also usable standalone as a reference model in benches.
- **Top level:** FSM, vec counter, settle counter, popcount and accumulators all live in the top.

## Test plan
- **Correct gate array, SETTLE=2:** `start` pulse → `done` at cycle 12, `pass`=1, `err_count`=0, `fail_mask`=7'h00; `{A,B}` steps 00, 01, 10, 11.
- **XOR output stuck at 0:** mismatches at vectors 01 and 10 → `err_count`=2, `fail_mask`=7'b0100000, `pass`=0.
- **All outputs inverted, ERR_W=5:** `err_count`=28, `fail_mask`=7'h7F. Repeat with ERR_W=4 → `err_count` saturates at 15.
- **`start` held high through a sweep:** exactly one `done` per sweep; a second sweep begins on the IDLE cycle after DONE, with counters cleared first.
- **`rst_n` low in the second vector's DRIVE:** all outputs 0 immediately, no `done`. A subsequent `start` completes normally.
- **NOT output driven as ~B:** mismatches at vectors 01 and 10 → `err_count`=2, `fail_mask`=7'b0010000.
